// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of the single main-memory port between the I-cache (rq0) and D-cache (rq1).
// Define MEM_ARB_TIMEOUT_EN to add a WAIT watchdog that aborts a hung memory access and raises a sticky timeout_err.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32,
   parameter int LINE_W = 512
`ifdef MEM_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rq0_addr,
   input  logic [WORD_W-1:0] rq0_wdata,
   input  logic              rq0_read_req,
   input  logic              rq0_write_req,
   output logic [LINE_W-1:0] rq0_rdata,
   output logic              rq0_ready,
   input  logic [ADDR_W-1:0] rq1_addr,
   input  logic [WORD_W-1:0] rq1_wdata,
   input  logic              rq1_read_req,
   input  logic              rq1_write_req,
   output logic [LINE_W-1:0] rq1_rdata,
   output logic              rq1_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_data_out,
   output logic              mem_read_req,
   output logic              mem_write_req,
   input  logic [LINE_W-1:0] mem_data_in,
   input  logic              mem_ready,
   output logic              grant_id,
   output logic              busy,
   output logic              timeout_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state;
   logic [1:0]        pend;
   logic              last_grant;
   logic              pick;
   logic [ADDR_W-1:0] lat_addr  [2];
   logic [WORD_W-1:0] lat_wdata [2];
   logic [1:0]        lat_wr;
   logic [ADDR_W-1:0] req_addr  [2];
   logic [WORD_W-1:0] req_wdata [2];
   logic [1:0]        req_rd;
   logic [1:0]        req_wr;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] wait_cnt;
`endif

   assign req_addr[0]  = rq0_addr;
   assign req_addr[1]  = rq1_addr;
   assign req_wdata[0] = rq0_wdata;
   assign req_wdata[1] = rq1_wdata;
   assign req_rd       = {rq1_read_req, rq0_read_req};
   assign req_wr       = {rq1_write_req, rq0_write_req};

   // On a tie the requester that did not win last time goes next.
   assign pick = (pend == 2'b11) ? ~last_grant : pend[1];
   assign busy = (state != IDLE);

   // A pulse is only taken when nothing is pending, so RESP's clear can never race a fresh capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend   <= '0;
         lat_wr <= '0;
         for (int i = 0; i < 2; i++) begin
            lat_addr[i]  <= '0;
            lat_wdata[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && (req_rd[i] || req_wr[i])) begin
               pend[i]      <= 1'b1;
               lat_addr[i]  <= req_addr[i];
               lat_wdata[i] <= req_wdata[i];
               lat_wr[i]    <= !req_rd[i];
            end else if (state == RESP && grant_id == 1'(i)) begin
               pend[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         grant_id      <= 1'b0;
         mem_addr      <= '0;
         mem_data_out  <= '0;
         mem_read_req  <= 1'b0;
         mem_write_req <= 1'b0;
         rq0_rdata     <= '0;
         rq1_rdata     <= '0;
         rq0_ready     <= 1'b0;
         rq1_ready     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         wait_cnt      <= '0;
         timeout_err   <= 1'b0;
`endif
      end else begin
         mem_read_req  <= 1'b0;
         mem_write_req <= 1'b0;
         rq0_ready     <= 1'b0;
         rq1_ready     <= 1'b0;
         case (state)
            IDLE: begin
               if (|pend) begin
                  grant_id      <= pick;
                  last_grant    <= pick;
                  mem_addr      <= lat_addr[pick];
                  mem_data_out  <= lat_wdata[pick];
                  mem_read_req  <= !lat_wr[pick];
                  mem_write_req <= lat_wr[pick];
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
`ifdef MEM_ARB_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               state <= WAIT;
            end
            WAIT: begin
               if (mem_ready) begin
                  if (!lat_wr[grant_id]) begin
                     if (grant_id) rq1_rdata <= mem_data_in;
                     else          rq0_rdata <= mem_data_in;
                  end
                  if (grant_id) rq1_ready <= 1'b1;
                  else          rq0_ready <= 1'b1;
                  state <= RESP;
               end
`ifdef MEM_ARB_TIMEOUT_EN
               // Abort returns an all-zero line so a stale line is never mistaken for fresh data.
               else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  if (grant_id) begin
                     rq1_rdata <= '0;
                     rq1_ready <= 1'b1;
                  end else begin
                     rq0_rdata <= '0;
                     rq0_ready <= 1'b1;
                  end
                  timeout_err <= 1'b1;
                  state       <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifndef MEM_ARB_TIMEOUT_EN
   assign timeout_err = 1'b0;
`endif

endmodule
